// File: rtl/cascade_timer_if.sv
// Control/status bundle for cascade_timer_ctrl.
// The periodic field exists only when CASCADE_TIMER_AUTO_RELOAD_EN is defined.
interface cascade_timer_if #(
  parameter int FAST_W = 4,
  parameter int SLOW_W = 3
);
  logic              start;
  logic              stop;
  logic [FAST_W-1:0] fast_max;
  logic [SLOW_W-1:0] slow_max;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
  logic              periodic;
`endif
  logic              busy;
  logic [FAST_W-1:0] fast_cnt;
  logic [SLOW_W-1:0] slow_cnt;
  logic              tick;
  logic              done;

`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
  modport master (output start, stop, fast_max, slow_max, periodic,
                  input  busy, fast_cnt, slow_cnt, tick, done);
  modport slave  (input  start, stop, fast_max, slow_max, periodic,
                  output busy, fast_cnt, slow_cnt, tick, done);
`else
  modport master (output start, stop, fast_max, slow_max,
                  input  busy, fast_cnt, slow_cnt, tick, done);
  modport slave  (input  start, stop, fast_max, slow_max,
                  output busy, fast_cnt, slow_cnt, tick, done);
`endif
endinterface

// File: rtl/cascade_timer_ctrl.sv
// Start/stop sequencer for a fast prescale counter cascaded into a slow counter.
// Define CASCADE_TIMER_AUTO_RELOAD_EN for periodic (auto-reload) runs.
module cascade_timer_ctrl #(
  parameter int FAST_W = 4,
  parameter int SLOW_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  cascade_timer_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [FAST_W-1:0] fast_max_q, fast_max_d, fast_q, fast_d;
  logic [SLOW_W-1:0] slow_max_q, slow_max_d, slow_q, slow_d;
  logic              busy_q, busy_d, tick_q, tick_d, done_q, done_d;
  logic              reload;

`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
  logic periodic_q, periodic_d;
  assign reload = periodic_q;
`else
  assign reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    fast_max_d = fast_max_q;
    slow_max_d = slow_max_q;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
    periodic_d = periodic_q;
`endif
    fast_d = fast_q;
    slow_d = slow_q;
    busy_d = busy_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // start+stop together is treated as no request
        if (bus.start && !bus.stop) begin
          fast_max_d = bus.fast_max;
          slow_max_d = bus.slow_max;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
          periodic_d = bus.periodic;
`endif
          fast_d  = '0;
          slow_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          fast_d  = '0;
          slow_d  = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (fast_q != fast_max_q) begin
          fast_d = FAST_W'(fast_q + 1'b1);
        end else begin
          fast_d = '0;
          tick_d = 1'b1;
          if (slow_q != slow_max_q) begin
            slow_d = SLOW_W'(slow_q + 1'b1);
          end else begin
            slow_d = '0;
            done_d = 1'b1;
            if (!reload) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_max_q <= '0;
      slow_max_q <= '0;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
      periodic_q <= 1'b0;
`endif
      fast_q <= '0;
      slow_q <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fast_max_q <= fast_max_d;
      slow_max_q <= slow_max_d;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
      periodic_q <= periodic_d;
`endif
      fast_q <= fast_d;
      slow_q <= slow_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.fast_cnt = fast_q;
  assign bus.slow_cnt = slow_q;
  assign bus.tick     = tick_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_cascade_timer_ctrl.sv
// Directed bench for cascade_timer_ctrl (one-shot and, with
// CASCADE_TIMER_AUTO_RELOAD_EN, periodic runs).
module tb_cascade_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  cascade_timer_if #(.FAST_W(4), .SLOW_W(3)) bus ();
  cascade_timer_ctrl #(.FAST_W(4), .SLOW_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " tick"}, 32'(bus.tick), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " fast"}, 32'(bus.fast_cnt), 0);
    chk({tag, " slow"}, 32'(bus.slow_cnt), 0);
  endtask

  // One-shot run; expectations come from the timing rules: run of
  // N=(fm+1)(sm+1) cycles, tick every fm+1 cycles, done at cycle N.
  // When meddle is set, start is held and the config inputs change mid-run.
  task automatic run_check(input string tag, input int fm, input int sm, input bit meddle);
    int n = (fm + 1) * (sm + 1);
    bus.fast_max = 4'(fm);
    bus.slow_max = 3'(sm);
    bus.start    = 1'b1;
    cyc();
    chk($sformatf("%s E0 busy", tag), 32'(bus.busy), 1);
    chk($sformatf("%s E0 fast", tag), 32'(bus.fast_cnt), 0);
    if (meddle) begin
      bus.fast_max = 4'd0;
      bus.slow_max = 3'd0;
    end else bus.start = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      if (c == 5) bus.start = 1'b0;
      cyc();
      chk($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), (c < n) ? 1 : 0);
      chk($sformatf("%s c%0d tick", tag, c), 32'(bus.tick), (c <= n && c % (fm + 1) == 0) ? 1 : 0);
      chk($sformatf("%s c%0d done", tag, c), 32'(bus.done), (c == n) ? 1 : 0);
      chk($sformatf("%s c%0d fast", tag, c), 32'(bus.fast_cnt), (c < n) ? c % (fm + 1) : 0);
      chk($sformatf("%s c%0d slow", tag, c), 32'(bus.slow_cnt), (c < n) ? c / (fm + 1) : 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.fast_max = '0;
    bus.slow_max = '0;
`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
    bus.periodic = 1'b0;
`endif
    #3;
    chk_idle("por");
    #5 rst_n = 1'b1;
    cyc();
    chk_idle("post-por");

    // async reset mid-run at slow_cnt=2
    bus.fast_max = 4'd5; bus.slow_max = 3'd3; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (12) cyc();
    chk("sweep slow", 32'(bus.slow_cnt), 2);
    chk("sweep busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_idle("async rst");
    #1 rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk_idle("rst idle");
    end

    run_check("oneshot", 3, 1, 1'b0);
    run_check("full", 15, 7, 1'b0);
    run_check("f0s2", 0, 2, 1'b0);
    run_check("f0s0", 0, 0, 1'b0);
    run_check("meddle", 3, 1, 1'b1);

    // start during the done cycle is accepted
    bus.fast_max = 4'd0; bus.slow_max = 3'd0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    chk("b2b done", 32'(bus.done), 1);
    chk("b2b gap busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("b2b restart busy", 32'(bus.busy), 1);
    cyc();
    chk("b2b 2nd done", 32'(bus.done), 1);

    // stop wins over the terminal count
    bus.fast_max = 4'd3; bus.slow_max = 3'd1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (7) cyc();
    chk("term fast", 32'(bus.fast_cnt), 3);
    chk("term slow", 32'(bus.slow_cnt), 1);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk_idle("stop@term");
    cyc();
    chk_idle("stop@term+1");

    // start and stop together in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    chk_idle("start+stop");
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_idle("start+stop 2");

`ifdef CASCADE_TIMER_AUTO_RELOAD_EN
    bus.fast_max = 4'd1; bus.slow_max = 3'd1; bus.periodic = 1'b1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0; bus.periodic = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk($sformatf("per c%0d busy", c), 32'(bus.busy), 1);
      chk($sformatf("per c%0d done", c), 32'(bus.done), (c % 4 == 0) ? 1 : 0);
      chk($sformatf("per c%0d tick", c), 32'(bus.tick), (c % 2 == 0) ? 1 : 0);
      chk($sformatf("per c%0d fast", c), 32'(bus.fast_cnt), c % 2);
      chk($sformatf("per c%0d slow", c), 32'(bus.slow_cnt), (c / 2) % 2);
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk_idle("per stop");
    cyc();
    chk_idle("per stop+1");
`else
    run_check("per-oneshot", 1, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim did not end, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
